led_pattern_ctrl: RTL and testbench

//   Sequencer for the 4-bit LED bank. Generates the step timebase and selects the pattern
//   (off, flow-left, flow-right, ping-pong), with run-time mode, speed and pause control.

---
 rtl/led_pattern_ctrl.sv | 113 +++++++++++
 tb/tb_led_pattern_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: programmable step timebase driving off / flow-left / flow-right /
// ping-pong patterns, with run-time mode, speed and pause control.
module led_pattern_ctrl #(
    parameter int unsigned TICK_DIV = 10,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       mode_load,
    input  logic [1:0] mode_sel,
    input  logic [1:0] speed_sel,
    input  logic       pause,
    output logic [3:0] led,
    output logic       step,
    output logic [1:0] mode_cur
);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_FLOW_L   = 2'd1,
        MODE_FLOW_R   = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    mode_e            mode_q;
    dir_e             dir_q;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] lim_c;
    logic [3:0]       led_nxt_c;
    dir_e             dir_nxt_c;
    logic [3:0]       seed_c;

    assign mode_cur = mode_q;

    // Terminal count for the currently latched speed.
    assign lim_c = CNT_W'((TICK_DIV << speed_q) - 32'd1);

    // Starting LED value for the mode being loaded.
    always_comb begin
        seed_c = 4'b0000;
        case (mode_e'(mode_sel))
            MODE_FLOW_L:   seed_c = 4'b0001;
            MODE_FLOW_R:   seed_c = 4'b1000;
            MODE_PINGPONG: seed_c = 4'b0001;
            default:       seed_c = 4'b0000;
        endcase
    end

    // Pattern advance applied on each step boundary.
    always_comb begin
        led_nxt_c = led;
        dir_nxt_c = dir_q;
        case (mode_q)
            MODE_FLOW_L: led_nxt_c = {led[2:0], led[3]};
            MODE_FLOW_R: led_nxt_c = {led[0], led[3:1]};
            MODE_PINGPONG: begin
                if (dir_q == DIR_LEFT) begin
                    led_nxt_c = {led[2:0], 1'b0};
                    if (led_nxt_c == 4'b1000) begin
                        dir_nxt_c = DIR_RIGHT;
                    end
                end else begin
                    led_nxt_c = {1'b0, led[3:1]};
                    if (led_nxt_c == 4'b0001) begin
                        dir_nxt_c = DIR_LEFT;
                    end
                end
            end
            default: led_nxt_c = 4'b0000;
        endcase
    end

    // Load beats pause beats count; OFF parks the counter at zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q  <= MODE_OFF;
            dir_q   <= DIR_LEFT;
            speed_q <= 2'd0;
            counter <= '0;
            led     <= 4'b0000;
            step    <= 1'b0;
        end else if (mode_load) begin
            mode_q  <= mode_e'(mode_sel);
            speed_q <= speed_sel;
            counter <= '0;
            step    <= 1'b0;
            led     <= seed_c;
            dir_q   <= DIR_LEFT;
        end else if (mode_q == MODE_OFF) begin
            counter <= '0;
            led     <= 4'b0000;
            step    <= 1'b0;
        end else if (pause) begin
            step    <= 1'b0;
        end else if (counter < lim_c) begin
            counter <= counter + CNT_W'(1);
            step    <= 1'b0;
        end else begin
            counter <= '0;
            step    <= 1'b1;
            speed_q <= speed_sel;
            led     <= led_nxt_c;
            dir_q   <= dir_nxt_c;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomized bench for led_pattern_ctrl against a table-driven pattern model.
module tb_led_pattern_ctrl;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned CNT_W    = 27;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       mode_load;
    logic [1:0] mode_sel;
    logic [1:0] speed_sel;
    logic       pause;
    logic [3:0] led;
    logic       step;
    logic [1:0] mode_cur;

    led_pattern_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mode_load (mode_load),
        .mode_sel  (mode_sel),
        .speed_sel (speed_sel),
        .pause     (pause),
        .led       (led),
        .step      (step),
        .mode_cur  (mode_cur)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position index into a per-mode pattern table.
    int m_mode, m_speed, m_cnt, m_idx;
    bit m_step;
    int pp_tab [6] = '{1, 2, 4, 8, 4, 2};

    function automatic int pat_len(input int mode);
        return (mode == 3) ? 6 : 4;
    endfunction

    function automatic int model_led();
        case (m_mode)
            1:       return 1 << m_idx;
            2:       return 8 >> m_idx;
            3:       return pp_tab[m_idx];
            default: return 0;
        endcase
    endfunction

    function automatic int model_lim();
        return TICK_DIV * (1 << m_speed) - 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_cnt = 0; m_idx = 0; m_step = 0;
    endtask

    task automatic model_clock(input bit ld, input int ms, input int ss, input bit ps);
        if (ld) begin
            m_mode = ms; m_speed = ss; m_cnt = 0; m_idx = 0; m_step = 0;
        end else if (m_mode == 0) begin
            m_cnt = 0; m_step = 0;
        end else if (ps) begin
            m_step = 0;
        end else if (m_cnt < model_lim()) begin
            m_cnt++; m_step = 0;
        end else begin
            m_cnt = 0; m_step = 1; m_speed = ss;
            m_idx = (m_idx + 1) % pat_len(m_mode);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("led", 32'(led), 32'(model_led()));
        check_val("step", 32'(step), 32'(m_step));
        check_val("mode_cur", 32'(mode_cur), 32'(m_mode));
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic cycle(input bit ld, input int ms, input int ss, input bit ps);
        @(negedge sys_clk);
        mode_load = ld;
        mode_sel  = 2'(ms);
        speed_sel = 2'(ss);
        pause     = ps;
        @(posedge sys_clk);
        model_clock(ld, ms, ss, ps);
        #1;
        check_outputs();
    endtask

    // Asserted between edges so the clear must appear with no clock edge.
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst   = 1'b1;
        mode_load = 1'b0;
        pause     = 1'b0;
        #1;
        model_reset();
        check_val("rst_led", 32'(led), 32'd0);
        check_val("rst_mode", 32'(mode_cur), 32'd0);
        check_val("rst_step", 32'(step), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b0; mode_load = 1'b0; mode_sel = 2'd0; speed_sel = 2'd0; pause = 1'b0;
        model_reset();
        do_reset();

        // Flow-left, flow-right, ping-pong at base speed.
        cycle(1, 1, 0, 0);
        check_val("seed_flow_l", 32'(led), 32'd1);
        repeat (45) cycle(0, 1, 0, 0);
        cycle(1, 2, 0, 0);
        check_val("seed_flow_r", 32'(led), 32'd8);
        repeat (50) cycle(0, 2, 0, 0);
        cycle(1, 3, 0, 0);
        repeat (130) cycle(0, 3, 0, 0);

        // Pause at counter=4, then speed change without a load.
        cycle(1, 1, 0, 0);
        repeat (4) cycle(0, 1, 0, 0);
        check_val("cnt_before_pause", 32'(m_cnt), 32'(dut.counter));
        repeat (25) cycle(0, 1, 0, 1);
        repeat (6) cycle(0, 1, 0, 0);
        check_val("step_after_pause", 32'(step), 32'd1);
        repeat (130) cycle(0, 1, 2, 0);

        // Load colliding with terminal count.
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 200 && m_cnt != model_lim(); i++) cycle(0, 1, 0, 0);
        check_val("at_terminal", 32'(m_cnt), 32'(model_lim()));
        cycle(1, 2, 0, 0);
        check_val("load_wins_step", 32'(step), 32'd0);
        check_val("load_wins_led", 32'(led), 32'd8);
        repeat (5) cycle(0, 2, 0, 0);
        do_reset();

        // OFF ignores pause and never steps; reload resumes.
        cycle(1, 0, 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 100; i++) cycle(0, 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        cycle(1, 1, 0, 0);
        repeat (45) cycle(0, 1, 0, 0);

        // Random traffic.
        begin
            int ss;
            ss = 0;
            for (int i = 0; i < 3000; i++) begin
                bit ld, ps;
                int ms;
                if (i == 1500) do_reset();
                if ($urandom_range(0, 99) == 0) ss = int'($urandom_range(0, 3));
                ld = ($urandom_range(0, 59) == 0);
                ms = int'($urandom_range(0, 3));
                ps = ($urandom_range(0, 7) == 0);
                cycle(ld, ms, ss, ps);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
